// File: rtl/bram_port_arbiter_if.sv
// rtl/bram_port_arbiter_if.sv - requester command/response channels and BRAM port bundle
interface bram_port_arbiter_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 10
);
    logic                  req0_valid;
    logic                  req0_ready;
    logic                  req0_we;
    logic [ADDR_WIDTH-1:0] req0_addr;
    logic [DATA_WIDTH-1:0] req0_wdata;
    logic                  rsp0_valid;
    logic [DATA_WIDTH-1:0] rsp0_rdata;

    logic                  req1_valid;
    logic                  req1_ready;
    logic                  req1_we;
    logic [ADDR_WIDTH-1:0] req1_addr;
    logic [DATA_WIDTH-1:0] req1_wdata;
    logic                  rsp1_valid;
    logic [DATA_WIDTH-1:0] rsp1_rdata;

    logic [ADDR_WIDTH-1:0] BRAM_ADDRA;
    logic [DATA_WIDTH-1:0] BRAM_DINA;
    logic                  BRAM_ENA;
    logic                  BRAM_WEA;
    logic [DATA_WIDTH-1:0] BRAM_DOUTA;

    modport slave (
        input  req0_valid, req0_we, req0_addr, req0_wdata,
        input  req1_valid, req1_we, req1_addr, req1_wdata,
        input  BRAM_DOUTA,
        output req0_ready, rsp0_valid, rsp0_rdata,
        output req1_ready, rsp1_valid, rsp1_rdata,
        output BRAM_ADDRA, BRAM_DINA, BRAM_ENA, BRAM_WEA
    );

    modport master (
        output req0_valid, req0_we, req0_addr, req0_wdata,
        output req1_valid, req1_we, req1_addr, req1_wdata,
        output BRAM_DOUTA,
        input  req0_ready, rsp0_valid, rsp0_rdata,
        input  req1_ready, rsp1_valid, rsp1_rdata,
        input  BRAM_ADDRA, BRAM_DINA, BRAM_ENA, BRAM_WEA
    );
endinterface

// File: rtl/bram_port_arbiter.sv
// rtl/bram_port_arbiter.sv - two-requester arbiter for one single-port BRAM with read tag pipeline
// BRAM_ARB_FIXED_PRIO_EN: requester 0 always wins contention (no round-robin pointer).
module bram_port_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 10,
    parameter int RD_LATENCY = 2
) (
    input  logic                CLKA,
    input  logic                RSTA,
    bram_port_arbiter_if.slave  bus
);
    logic grant0;
    logic grant1;

`ifdef BRAM_ARB_FIXED_PRIO_EN
    always_comb begin
        grant0 = bus.req0_valid;
        grant1 = bus.req1_valid && !bus.req0_valid;
    end
`else
    // last_grant1 remembers who won the most recent accept; reset favours requester 0.
    logic last_grant1;

    always_comb begin
        grant0 = bus.req0_valid && (!bus.req1_valid || last_grant1);
        grant1 = bus.req1_valid && (!bus.req0_valid || !last_grant1);
    end

    always_ff @(posedge CLKA) begin
        if (RSTA) begin
            last_grant1 <= 1'b1;
        end else if (grant0 || grant1) begin
            last_grant1 <= grant1;
        end
    end
`endif

    logic                  accept;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    assign bus.req0_ready = grant0 && !RSTA;
    assign bus.req1_ready = grant1 && !RSTA;
    assign accept         = (grant0 || grant1) && !RSTA;
    assign sel_we         = grant1 ? bus.req1_we    : bus.req0_we;
    assign sel_addr       = grant1 ? bus.req1_addr  : bus.req0_addr;
    assign sel_wdata      = grant1 ? bus.req1_wdata : bus.req0_wdata;

    logic                  ena_q;
    logic                  wea_q;
    logic                  owner_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] dina_q;

    always_ff @(posedge CLKA) begin
        if (RSTA) begin
            ena_q   <= 1'b0;
            wea_q   <= 1'b0;
            owner_q <= 1'b0;
            addr_q  <= '0;
            dina_q  <= '0;
        end else begin
            ena_q <= accept;
            wea_q <= accept && sel_we;
            if (accept) begin
                owner_q <= grant1;
                addr_q  <= sel_addr;
                dina_q  <= sel_wdata;
            end
        end
    end

    assign bus.BRAM_ENA   = ena_q;
    assign bus.BRAM_WEA   = wea_q;
    assign bus.BRAM_ADDRA = addr_q;
    assign bus.BRAM_DINA  = dina_q;

    // Tags enter when the BRAM samples the read, so stage RD_LATENCY lines up with DOUTA.
    logic [1:0] tag_pipe [RD_LATENCY+1];

    always_ff @(posedge CLKA) begin
        if (RSTA) begin
            for (int i = 0; i <= RD_LATENCY; i++) begin
                tag_pipe[i] <= 2'b00;
            end
        end else begin
            tag_pipe[0] <= {ena_q && !wea_q, owner_q};
            for (int i = 1; i <= RD_LATENCY; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    assign bus.rsp0_valid = tag_pipe[RD_LATENCY][1] && !tag_pipe[RD_LATENCY][0];
    assign bus.rsp1_valid = tag_pipe[RD_LATENCY][1] &&  tag_pipe[RD_LATENCY][0];
    assign bus.rsp0_rdata = bus.BRAM_DOUTA;
    assign bus.rsp1_rdata = bus.BRAM_DOUTA;
endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb/tb_bram_port_arbiter.sv - directed bench for bram_port_arbiter at RD_LATENCY 2 and 0
module tb_bram_port_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    bram_port_arbiter_if #(.DATA_WIDTH(64), .ADDR_WIDTH(10)) ifa ();
    bram_port_arbiter_if #(.DATA_WIDTH(64), .ADDR_WIDTH(10)) ifb ();

    bram_port_arbiter #(.DATA_WIDTH(64), .ADDR_WIDTH(10), .RD_LATENCY(2)) dut_a (
        .CLKA (clk),
        .RSTA (rst),
        .bus  (ifa)
    );

    bram_port_arbiter #(.DATA_WIDTH(64), .ADDR_WIDTH(10), .RD_LATENCY(0)) dut_b (
        .CLKA (clk),
        .RSTA (rst),
        .bus  (ifb)
    );

    // Registered-output BRAM: address sampled, then two output register stages.
    logic [63:0] mem_a [1024];
    logic [9:0]  aq_a;
    logic [63:0] d1_a, d2_a;
    always @(posedge clk) begin
        if (ifa.BRAM_ENA) begin
            if (ifa.BRAM_WEA) mem_a[ifa.BRAM_ADDRA] <= ifa.BRAM_DINA;
            aq_a <= ifa.BRAM_ADDRA;
        end
        d1_a <= mem_a[aq_a];
        d2_a <= d1_a;
    end
    assign ifa.BRAM_DOUTA = d2_a;

    // Combinational-read BRAM: data follows the sampled address directly.
    logic [63:0] mem_b [1024];
    logic [9:0]  aq_b;
    always @(posedge clk) begin
        if (ifb.BRAM_ENA) begin
            if (ifb.BRAM_WEA) mem_b[ifb.BRAM_ADDRA] <= ifb.BRAM_DINA;
            aq_b <= ifb.BRAM_ADDRA;
        end
    end
    assign ifb.BRAM_DOUTA = mem_b[aq_b];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_rsp_a(input string tag, input logic v0, input logic v1);
        check({tag, "_rsp0_valid"}, ifa.rsp0_valid, v0);
        check({tag, "_rsp1_valid"}, ifa.rsp1_valid, v1);
    endtask

    task automatic drive_a0(input logic v, input logic we, input logic [9:0] addr, input logic [63:0] wd);
        ifa.req0_valid = v; ifa.req0_we = we; ifa.req0_addr = addr; ifa.req0_wdata = wd;
    endtask

    task automatic drive_a1(input logic v, input logic we, input logic [9:0] addr, input logic [63:0] wd);
        ifa.req1_valid = v; ifa.req1_we = we; ifa.req1_addr = addr; ifa.req1_wdata = wd;
    endtask

    logic        exp_r0;
    logic        exp_o1;
    logic [63:0] exp_d;

    initial begin
        drive_a0(1'b1, 1'b0, 10'd0, 64'd0);
        drive_a1(1'b0, 1'b0, 10'd0, 64'd0);
        ifb.req0_valid = 1'b0; ifb.req0_we = 1'b0; ifb.req0_addr = '0; ifb.req0_wdata = '0;
        ifb.req1_valid = 1'b0; ifb.req1_we = 1'b0; ifb.req1_addr = '0; ifb.req1_wdata = '0;
        repeat (3) tick();

        @(negedge clk);
        check("rst_ena", ifa.BRAM_ENA, 1'b0);
        check("rst_wea", ifa.BRAM_WEA, 1'b0);
        check("rst_addra", ifa.BRAM_ADDRA, 10'd0);
        check("rst_dina", ifa.BRAM_DINA, 64'd0);
        check("rst_ready0", ifa.req0_ready, 1'b0);
        check("rst_ready1", ifa.req1_ready, 1'b0);
        chk_rsp_a("rst", 1'b0, 1'b0);
        tick();

        // Write then read of address 5 on the latency-2 instance.
        rst = 1'b0;
        drive_a0(1'b1, 1'b1, 10'd5, 64'hDEAD_BEEF);
        @(negedge clk);
        check("wr_ready0", ifa.req0_ready, 1'b1);
        check("wr_ready1", ifa.req1_ready, 1'b0);
        tick();
        drive_a0(1'b1, 1'b0, 10'd5, 64'd0);
        @(negedge clk);
        check("wr_ena", ifa.BRAM_ENA, 1'b1);
        check("wr_wea", ifa.BRAM_WEA, 1'b1);
        check("wr_addra", ifa.BRAM_ADDRA, 10'd5);
        check("wr_dina", ifa.BRAM_DINA, 64'hDEAD_BEEF);
        tick();
        drive_a0(1'b0, 1'b0, 10'd0, 64'd0);
        @(negedge clk);
        check("rd_ena", ifa.BRAM_ENA, 1'b1);
        check("rd_wea", ifa.BRAM_WEA, 1'b0);
        check("rd_addra", ifa.BRAM_ADDRA, 10'd5);
        chk_rsp_a("rd_c1", 1'b0, 1'b0);
        tick();
        @(negedge clk);
        check("idle_ena", ifa.BRAM_ENA, 1'b0);
        chk_rsp_a("rd_c2", 1'b0, 1'b0);
        tick();
        @(negedge clk);
        chk_rsp_a("rd_c3", 1'b0, 1'b0);
        tick();
        @(negedge clk);
        chk_rsp_a("rd_c4", 1'b1, 1'b0);
        check("rd_rdata", ifa.rsp0_rdata, 64'hDEAD_BEEF);
        tick();
        @(negedge clk);
        chk_rsp_a("rd_c5", 1'b0, 1'b0);
        tick();

        // Preload; the second write comes from requester 1 so requester 0 is next in line.
        drive_a0(1'b1, 1'b1, 10'd1, 64'h11);
        tick();
        drive_a0(1'b0, 1'b0, 10'd0, 64'd0);
        drive_a1(1'b1, 1'b1, 10'd2, 64'h22);
        @(negedge clk);
        check("pre_ready1", ifa.req1_ready, 1'b1);
        tick();

        drive_a0(1'b1, 1'b0, 10'd1, 64'd0);
        drive_a1(1'b1, 1'b0, 10'd2, 64'd0);
        for (int i = 0; i < 4; i++) begin
`ifdef BRAM_ARB_FIXED_PRIO_EN
            exp_r0 = 1'b1;
`else
            exp_r0 = (i % 2 == 0);
`endif
            @(negedge clk);
            check($sformatf("cont_ready0_%0d", i), ifa.req0_ready, exp_r0);
            check($sformatf("cont_ready1_%0d", i), ifa.req1_ready, !exp_r0);
            tick();
        end
        drive_a0(1'b0, 1'b0, 10'd0, 64'd0);
        drive_a1(1'b0, 1'b0, 10'd0, 64'd0);
        for (int j = 0; j < 4; j++) begin
`ifdef BRAM_ARB_FIXED_PRIO_EN
            exp_o1 = 1'b0;
`else
            exp_o1 = (j % 2 == 1);
`endif
            exp_d = exp_o1 ? 64'h22 : 64'h11;
            @(negedge clk);
            chk_rsp_a($sformatf("cont_rsp%0d", j), !exp_o1, exp_o1);
            check($sformatf("cont_rdata%0d", j), exp_o1 ? ifa.rsp1_rdata : ifa.rsp0_rdata, exp_d);
            tick();
        end
        @(negedge clk);
        chk_rsp_a("cont_after", 1'b0, 1'b0);
        tick();

        // Reset with two reads in flight.
        drive_a0(1'b1, 1'b0, 10'd3, 64'd0);
        tick();
        drive_a0(1'b0, 1'b0, 10'd0, 64'd0);
        drive_a1(1'b1, 1'b0, 10'd4, 64'd0);
        tick();
        drive_a1(1'b0, 1'b0, 10'd0, 64'd0);
        @(negedge clk);
        chk_rsp_a("mid_c1", 1'b0, 1'b0);
        tick();
        rst = 1'b1;
        drive_a0(1'b1, 1'b1, 10'd3, 64'd0);
        drive_a1(1'b1, 1'b1, 10'd4, 64'd0);
        @(negedge clk);
        check("mid_rst_ready0", ifa.req0_ready, 1'b0);
        check("mid_rst_ready1", ifa.req1_ready, 1'b0);
        chk_rsp_a("mid_c2", 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("mid_ena", ifa.BRAM_ENA, 1'b0);
        check("mid_post_ready0", ifa.req0_ready, 1'b1);
        check("mid_post_ready1", ifa.req1_ready, 1'b0);
        chk_rsp_a("mid_c3", 1'b0, 1'b0);
        tick();
        drive_a0(1'b0, 1'b0, 10'd0, 64'd0);
        drive_a1(1'b0, 1'b0, 10'd0, 64'd0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk_rsp_a($sformatf("mid_quiet%0d", k), 1'b0, 1'b0);
            tick();
        end

        // Pointer must survive idle cycles.
        drive_a1(1'b1, 1'b1, 10'd9, 64'h99);
        @(negedge clk);
        check("hold_ready1", ifa.req1_ready, 1'b1);
        tick();
        drive_a1(1'b0, 1'b0, 10'd0, 64'd0);
        repeat (5) tick();
        drive_a0(1'b1, 1'b1, 10'd10, 64'hA);
        drive_a1(1'b1, 1'b1, 10'd11, 64'hB);
        @(negedge clk);
        check("hold_ready0", ifa.req0_ready, 1'b1);
        check("hold_ready1b", ifa.req1_ready, 1'b0);
        tick();
        drive_a0(1'b0, 1'b0, 10'd0, 64'd0);
        drive_a1(1'b0, 1'b0, 10'd0, 64'd0);

        // Latency-0 instance with combinational-read BRAM.
        ifb.req1_valid = 1'b1; ifb.req1_we = 1'b1; ifb.req1_addr = 10'd7; ifb.req1_wdata = 64'h77;
        tick();
        ifb.req1_we = 1'b0; ifb.req1_wdata = 64'd0;
        @(negedge clk);
        check("l0_ready1", ifb.req1_ready, 1'b1);
        tick();
        ifb.req1_valid = 1'b0;
        @(negedge clk);
        check("l0_ena", ifb.BRAM_ENA, 1'b1);
        check("l0_rsp1_early", ifb.rsp1_valid, 1'b0);
        tick();
        @(negedge clk);
        check("l0_rsp1_valid", ifb.rsp1_valid, 1'b1);
        check("l0_rsp0_valid", ifb.rsp0_valid, 1'b0);
        check("l0_rdata", ifb.rsp1_rdata, 64'h77);
        tick();
        @(negedge clk);
        check("l0_rsp1_after", ifb.rsp1_valid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1);
    end
endmodule

// File: doc/bram_port_arbiter.md
Name: bram_port_arbiter

Overview:
- Shares one single-port BRAM (blk_mem_gen-style: ADDRA/DINA/DOUTA/ENA/WEA) between two requesters using per-requester valid/ready command channels.
- Registers the winning command onto the BRAM port.
- Tracks in-flight reads in a latency-matched tag pipeline and returns read data to the issuing requester with a one-cycle rsp_valid strobe.
- Sits between the NPU-side masters (e.g. AXI slave front-end and local compute engine) and the data buffer BRAM.

Parameters:
- DATA_WIDTH, 64, BRAM word width.
- ADDR_WIDTH, 10, BRAM address width.
- RD_LATENCY, 2, BRAM read latency in CLKA edges after the address is sampled. 2 matches the registered-output model; 0 matches the combinational-read model. Legal range 0..4.

Ports:
- CLKA  in  1  clock, shared with the BRAM.
- RSTA  in  1  synchronous active-high reset.
- req0_valid  in  1  requester 0 command valid.
- req0_ready  out  1  requester 0 command accepted this cycle.
- req0_we  in  1  1=write, 0=read.
- req0_addr  in  ADDR_WIDTH  word address.
- req0_wdata  in  DATA_WIDTH  write data.
- rsp0_valid  out  1  read data valid for requester 0.
- rsp0_rdata  out  DATA_WIDTH  read data.
- req1_*, rsp1_*  same set as requester 0, for requester 1.
- BRAM_ADDRA  out  ADDR_WIDTH  to BRAM ADDRA.
- BRAM_DINA  out  DATA_WIDTH  to BRAM DINA.
- BRAM_ENA  out  1  to BRAM ENA.
- BRAM_WEA  out  1  to BRAM WEA.
- BRAM_DOUTA  in  DATA_WIDTH  from BRAM DOUTA.

Behaviour:
- **Clock and reset:** single clock CLKA; reset RSTA is synchronous, active-high.
- **Reset values:**
  - BRAM_ENA=0, BRAM_WEA=0, BRAM_ADDRA=0, BRAM_DINA=0.
  - req0_ready=0 and req1_ready=0 while RSTA=1.
  - rsp0_valid=0, rsp1_valid=0, tag pipeline cleared.
  - Round-robin pointer set so requester 0 wins the first contention.
  - BRAM contents are not affected.
- **Arbitration:** combinational grant each cycle.
  - Only one valid: that requester is granted.
  - Both valid: the requester not granted most recently wins.
  - req_ready = grant. A command is accepted on an edge where valid&&ready.
  - At most one accept per cycle; the arbiter never back-pressures when the port is free. Throughput is 1 command/cycle.
- **Round-robin pointer:** updates only on an accept. Idle cycles do not change it.
- **Handshake rules:**
  - A requester may hold valid and change addr/we/wdata freely until accepted.
  - No dependency of valid on ready.
- **Command register:** on accept at edge t, BRAM_ENA=1, BRAM_WEA=req_we, BRAM_ADDRA=req_addr and BRAM_DINA=req_wdata are driven during the cycle after edge t. With no accept, BRAM_ENA=0 and BRAM_WEA=0. ADDRA/DINA hold their last value.
- **Read tag pipeline:**
  - Each issued read pushes {valid, owner} into a shift register of depth RD_LATENCY+1.
  - rspN_valid is high for exactly one cycle: the cycle after edge t+1+RD_LATENCY, when owner==N.
  - rspN_rdata = BRAM_DOUTA combinationally, for both N.
  - Writes produce no response.
- **Ordering:** responses return in issue order. Back-to-back reads from alternating requesters produce alternating single-cycle rsp strobes with no gaps.
- **Read-after-write:** a write accepted at edge t followed by a read of the same address accepted at edge t+1 returns the new data.
- **Reset mid-operation:** all in-flight read tags are dropped and no rsp_valid fires after reset deasserts for commands issued before reset. The pointer returns to the requester-0-first state.
- **Address:** used unmodified; no wrap/bound checking.

Optional Feature:
- Macro: BRAM_ARB_FIXED_PRIO_EN.
- Defined: requester 0 always wins when both are valid, and the pointer logic is removed. Requester 1 may starve.
- Undefined: round-robin as above.

Test Plan:
- **Single write then read:** after reset, req0 writes addr 5, data 0xDEAD_BEEF; next cycle req0 reads addr 5 -> BRAM_ENA=1, BRAM_WEA=1, BRAM_ADDRA=5 one cycle after the write accept. With RD_LATENCY=2, rsp0_valid is high for exactly one cycle, 3 cycles after the read accept, with rsp0_rdata=0xDEAD_BEEF. rsp1_valid stays 0.
- **Contention round-robin:** preload addr 1=0x11 and addr 2=0x22; req0 and req1 both hold valid reads of addr 1 and addr 2 for 4 cycles -> grants go 0,1,0,1. Responses alternate rsp0 (0x11), rsp1 (0x22) on consecutive cycles.
- **Fixed-priority build:** with BRAM_ARB_FIXED_PRIO_EN, same stimulus as the contention test -> req0_ready=1 all 4 cycles, req1_ready=0 throughout.
- **RD_LATENCY=0 instance with the combinational BRAM:** req1 reads addr 7 holding 0x77 -> rsp1_valid is high in the cycle after accept with rsp1_rdata=0x77.
- **Reset mid-flight:** issue reads to addr 3 and addr 4, then assert RSTA one cycle after the second accept, for 1 cycle -> no rsp valid ever fires. BRAM_ENA=0 and both ready signals are 0 during reset. The next contention is won by req0.
- **Idle pointer hold:** grant req1, idle 5 cycles, then both valid -> req0 wins.
